// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the memory-stage access controller: mem_sel codes,
// bus size codes, FSM states and the lane/strobe/alignment helpers.
package mem_pkg;

  localparam logic [1:0] MEM_SC   = 2'd0;
  localparam logic [1:0] MEM_BYTE = 2'd1;
  localparam logic [1:0] MEM_HALF = 2'd2;
  localparam logic [1:0] MEM_WORD = 2'd3;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic [1:0] sizeOf(input logic [1:0] sel);
    logic [1:0] size;
    case (sel)
      MEM_BYTE: size = SIZE_BYTE;
      MEM_HALF: size = SIZE_HALF;
      default:  size = SIZE_WORD;
    endcase
    return size;
  endfunction

  function automatic logic [3:0] strbOf(input logic [1:0] sel, input logic [1:0] lane);
    logic [3:0] strb;
    case (sel)
      MEM_BYTE: strb = 4'b0001 << lane;
      MEM_HALF: strb = 4'b0011 << lane;
      default:  strb = 4'b1111;
    endcase
    return strb;
  endfunction

  function automatic logic [31:0] repData(input logic [1:0] sel, input logic [31:0] data);
    logic [31:0] rep;
    case (sel)
      MEM_BYTE: rep = {4{data[7:0]}};
      MEM_HALF: rep = {2{data[15:0]}};
      default:  rep = data;
    endcase
    return rep;
  endfunction

  // Move the addressed lane down to bit 0, then trim and extend to 32 bits.
  function automatic logic [31:0] alignLoad(input logic [1:0] sel, input logic sext,
                                            input logic [1:0] lane, input logic [31:0] raw);
    logic [31:0] shifted;
    logic [31:0] result;
    shifted = raw >> {lane, 3'b000};
    case (sel)
      MEM_BYTE: result = {{24{sext & shifted[7]}}, shifted[7:0]};
      MEM_HALF: result = {{16{sext & shifted[15]}}, shifted[15:0]};
      default:  result = shifted;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side and data-bus-side signals of the memory access controller.
interface mem_access_ctrl_if;
  logic        valid;
  logic        we;
  logic [1:0]  mem_sel;
  logic        sign_ext;
  logic        ll;
  logic        llbit_clr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        stall;
  logic        sc_result;
  logic        adel;
  logic        ades;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport slave (
    input  valid, we, mem_sel, sign_ext, ll, llbit_clr, addr, wdata,
    output rdata, done, stall, sc_result, adel, ades,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport master (
    output valid, we, mem_sel, sign_ext, ll, llbit_clr, addr, wdata,
    input  rdata, done, stall, sc_result, adel, ades,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access_ctrl_llbit.sv
// LL/SC link bit: clear has priority over set, asynchronous reset.
module llbit_reg (
  input  logic clk,
  input  logic rst,
  input  logic set_i,
  input  logic clr_i,
  output logic llbit_o
);

  logic llbit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      llbit_q <= 1'b0;
    end else if (clr_i) begin
      llbit_q <= 1'b0;
    end else if (set_i) begin
      llbit_q <= 1'b1;
    end
  end

  assign llbit_o = llbit_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller driving the SRAM-like data bus.
// Define MEM_ALIGN_CHECK_EN to trap misaligned accesses via adel/ades.
module mem_access_ctrl
  import mem_pkg::*;
(
  input logic              clk,
  input logic              rst,
  mem_access_ctrl_if.slave mif
);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  sel_q, sel_d;
  logic        sext_q, sext_d;
  logic        ll_q, ll_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        scResult_q, scResult_d;
  logic        adel_q, adel_d;
  logic        ades_q, ades_d;

  logic        misalign;
  logic [31:0] addrIn;
  logic        scReq;
  logic        llbit;
  logic        llSet;
  logic        llClr;
  logic        busReq;
  logic        dataDone;

`ifdef MEM_ALIGN_CHECK_EN
  always_comb begin
    addrIn   = mif.addr;
    misalign = ((mif.mem_sel == MEM_HALF) && mif.addr[0]) ||
               (((mif.mem_sel == MEM_WORD) || (mif.mem_sel == MEM_SC)) && (mif.addr[1:0] != 2'b00));
  end
`else
  // Without the check, misaligned halves/words silently round down to their natural boundary.
  always_comb begin
    addrIn   = mif.addr;
    misalign = 1'b0;
    if (mif.mem_sel == MEM_HALF) begin
      addrIn[0] = 1'b0;
    end else if ((mif.mem_sel == MEM_WORD) || (mif.mem_sel == MEM_SC)) begin
      addrIn[1:0] = 2'b00;
    end
  end
`endif

  assign scReq    = mif.we && (mif.mem_sel == MEM_SC);
  assign busReq   = (state_q == ST_REQ);
  assign dataDone = (state_q == ST_WAIT) && mif.data_data_ok;

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    sel_d      = sel_q;
    sext_d     = sext_q;
    ll_d       = ll_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    scResult_d = scResult_q;
    adel_d     = adel_q;
    ades_d     = ades_q;
    case (state_q)
      ST_IDLE: begin
        if (mif.valid) begin
          we_d       = mif.we;
          sel_d      = mif.mem_sel;
          sext_d     = mif.sign_ext;
          ll_d       = mif.ll;
          addr_d     = addrIn;
          wdata_d    = mif.wdata;
          rdata_d    = 32'h0;
          scResult_d = 1'b0;
          adel_d     = misalign & ~mif.we;
          ades_d     = misalign & mif.we;
          if (misalign || (scReq && !llbit)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mif.data_addr_ok) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mif.data_data_ok) begin
          state_d = ST_DONE;
          if (!we_q) begin
            rdata_d = alignLoad(sel_q, sext_q, addr_q[1:0], mif.data_rdata);
          end else if (sel_q == MEM_SC) begin
            scResult_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Any sc that finishes, on the bus or short-circuited, consumes the link.
  assign llSet = dataDone && !we_q && ll_q;
  assign llClr = mif.llbit_clr ||
                 (dataDone && we_q && (sel_q == MEM_SC)) ||
                 ((state_q == ST_IDLE) && mif.valid && scReq && (misalign || !llbit));

  llbit_reg u_llbit (
    .clk     (clk),
    .rst     (rst),
    .set_i   (llSet),
    .clr_i   (llClr),
    .llbit_o (llbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      sel_q      <= MEM_SC;
      sext_q     <= 1'b0;
      ll_q       <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      scResult_q <= 1'b0;
      adel_q     <= 1'b0;
      ades_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      sext_q     <= sext_d;
      ll_q       <= ll_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      scResult_q <= scResult_d;
      adel_q     <= adel_d;
      ades_q     <= ades_d;
    end
  end

  assign mif.rdata      = rdata_q;
  assign mif.sc_result  = scResult_q;
  assign mif.adel       = adel_q;
  assign mif.ades       = ades_q;
  assign mif.done       = (state_q == ST_DONE);
  assign mif.stall      = ((state_q == ST_IDLE) && mif.valid) || busReq || (state_q == ST_WAIT);

  // Bus controls are only driven while a request is outstanding, so they idle at zero.
  assign mif.data_req   = busReq;
  assign mif.data_wr    = busReq & we_q;
  assign mif.data_size  = busReq ? sizeOf(sel_q) : 2'b00;
  assign mif.data_wstrb = (busReq && we_q) ? strbOf(sel_q, addr_q[1:0]) : 4'b0000;
  assign mif.data_addr  = busReq ? addr_q : 32'h0;
  assign mif.data_wdata = (busReq && we_q) ? repData(sel_q, wdata_q) : 32'h0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a scripted data-bus responder.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  logic clk;
  logic rst;
  int   checkCount;
  int   errorCount;

  int          obsDoneCycle;
  int          obsReqCycles;
  logic        obsStallOk;
  logic        obsReqStable;
  logic        obsDoneLeft;
  logic [31:0] obsAddr;
  logic [31:0] obsWdata;
  logic [6:0]  obsCtrl;
  logic [31:0] obsRdata;
  logic        obsSc;
  logic        obsAdel;
  logic        obsAdes;
  logic        finished;

  mem_access_ctrl_if mif ();

  mem_access_ctrl dut (
    .clk (clk),
    .rst (rst),
    .mif (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Issues one request at a negedge, then plays the bus: addr_ok after aDly REQ cycles,
  // data_ok after dDly WAIT cycles. Cycle numbers count from the valid cycle (0).
  task automatic applyStimulus(input logic we, input logic [1:0] sel, input logic sext,
                               input logic ll, input logic [31:0] addr, input logic [31:0] wdata,
                               input int aDly, input int dDly, input logic [31:0] busData);
    int reqIdx;
    int waitIdx;
    reqIdx       = 0;
    waitIdx      = 0;
    finished     = 1'b0;
    obsDoneCycle = -1;
    obsStallOk   = 1'b1;
    obsReqStable = 1'b1;
    obsAddr      = 32'h0;
    obsWdata     = 32'h0;
    obsCtrl      = 7'h0;
    @(negedge clk);
    obsDoneLeft  = mif.done;
    mif.valid    = 1'b1;
    mif.we       = we;
    mif.mem_sel  = sel;
    mif.sign_ext = sext;
    mif.ll       = ll;
    mif.addr     = addr;
    mif.wdata    = wdata;
    #1;
    if (!mif.stall) obsStallOk = 1'b0;
    for (int cyc = 1; cyc <= 40 && !finished; cyc++) begin
      @(negedge clk);
      mif.valid        = 1'b0;
      mif.data_addr_ok = 1'b0;
      mif.data_data_ok = 1'b0;
      mif.data_rdata   = 32'hA5A5_A5A5;
      if (mif.done) begin
        finished     = 1'b1;
        obsDoneCycle = cyc;
        obsRdata     = mif.rdata;
        obsSc        = mif.sc_result;
        obsAdel      = mif.adel;
        obsAdes      = mif.ades;
        if (mif.stall) obsStallOk = 1'b0;
      end else begin
        if (!mif.stall) obsStallOk = 1'b0;
        if (mif.data_req) begin
          if (reqIdx == 0) begin
            obsAddr  = mif.data_addr;
            obsWdata = mif.data_wdata;
            obsCtrl  = {mif.data_wr, mif.data_size, mif.data_wstrb};
          end else if (obsAddr !== mif.data_addr || obsWdata !== mif.data_wdata ||
                       obsCtrl !== {mif.data_wr, mif.data_size, mif.data_wstrb}) begin
            obsReqStable = 1'b0;
          end
          if (reqIdx == aDly) mif.data_addr_ok = 1'b1;
          reqIdx++;
        end else if (reqIdx > 0) begin
          if (waitIdx == dDly) begin
            mif.data_data_ok = 1'b1;
            mif.data_rdata   = busData;
          end
          waitIdx++;
        end
      end
    end
    obsReqCycles = reqIdx;
    checkOutput("no_timeout", {31'h0, finished}, 32'h1);
  endtask

  initial begin
    checkCount       = 0;
    errorCount       = 0;
    rst              = 1'b1;
    mif.valid        = 1'b0;
    mif.we           = 1'b0;
    mif.mem_sel      = MEM_SC;
    mif.sign_ext     = 1'b0;
    mif.ll           = 1'b0;
    mif.llbit_clr    = 1'b0;
    mif.addr         = 32'h0;
    mif.wdata        = 32'h0;
    mif.data_addr_ok = 1'b0;
    mif.data_data_ok = 1'b0;
    mif.data_rdata   = 32'h0;
    repeat (2) @(negedge clk);
    checkOutput("rst_flags", {27'h0, mif.done, mif.stall, mif.sc_result, mif.adel, mif.ades}, 32'h0);
    checkOutput("rst_rdata", mif.rdata, 32'h0);
    checkOutput("rst_busctl", {25'h0, mif.data_req, mif.data_wr, mif.data_size, mif.data_wstrb}, 32'h0);
    checkOutput("rst_busaddr", mif.data_addr, 32'h0);
    checkOutput("rst_buswdata", mif.data_wdata, 32'h0);
    rst = 1'b0;

    $display("[TB] sb to 0x1003");
    applyStimulus(1'b1, MEM_BYTE, 1'b0, 1'b0, 32'h0000_1003, 32'h0000_00AB, 0, 0, 32'h0);
    checkOutput("sb_done_cycle", obsDoneCycle, 32'd3);
    checkOutput("sb_ctrl", {25'h0, obsCtrl}, {25'h0, 1'b1, 2'd0, 4'b1000});
    checkOutput("sb_wdata", obsWdata, 32'hABAB_ABAB);
    checkOutput("sb_addr", obsAddr, 32'h0000_1003);

    $display("[TB] lh from 0x2002");
    applyStimulus(1'b0, MEM_HALF, 1'b1, 1'b0, 32'h0000_2002, 32'h0, 0, 0, 32'h8001_1234);
    checkOutput("lh_back_to_back", obsDoneLeft, 1'b0);
    checkOutput("lh_ctrl", {25'h0, obsCtrl}, {25'h0, 1'b0, 2'd1, 4'b0000});
    checkOutput("lh_rdata", obsRdata, 32'hFFFF_8001);
    applyStimulus(1'b0, MEM_HALF, 1'b0, 1'b0, 32'h0000_2002, 32'h0, 0, 0, 32'h8001_1234);
    checkOutput("lhu_rdata", obsRdata, 32'h0000_8001);

    $display("[TB] lw with slow handshake");
    applyStimulus(1'b0, MEM_WORD, 1'b0, 1'b0, 32'h0000_5000, 32'h0, 4, 3, 32'hDEAD_BEEF);
    checkOutput("lw_done_cycle", obsDoneCycle, 32'd10);
    checkOutput("lw_req_cycles", obsReqCycles, 32'd5);
    checkOutput("lw_req_stable", obsReqStable, 1'b1);
    checkOutput("lw_stall", obsStallOk, 1'b1);
    checkOutput("lw_rdata", obsRdata, 32'hDEAD_BEEF);

    $display("[TB] byte loads and half store");
    applyStimulus(1'b0, MEM_BYTE, 1'b1, 1'b0, 32'h0000_6001, 32'h0, 0, 0, 32'h0000_80FF);
    checkOutput("single_done", obsDoneLeft, 1'b0);
    checkOutput("lb_rdata", obsRdata, 32'hFFFF_FF80);
    applyStimulus(1'b0, MEM_BYTE, 1'b0, 1'b0, 32'h0000_6001, 32'h0, 0, 0, 32'h0000_80FF);
    checkOutput("lbu_rdata", obsRdata, 32'h0000_0080);
    applyStimulus(1'b1, MEM_HALF, 1'b0, 1'b0, 32'h0000_7002, 32'hCAFE_1234, 0, 0, 32'h0);
    checkOutput("sh_ctrl", {25'h0, obsCtrl}, {25'h0, 1'b1, 2'd1, 4'b1100});
    checkOutput("sh_wdata", obsWdata, 32'h1234_1234);

    $display("[TB] ll then sc twice");
    applyStimulus(1'b0, MEM_WORD, 1'b0, 1'b1, 32'h0000_3000, 32'h0, 0, 0, 32'h1234_5678);
    checkOutput("ll_rdata", obsRdata, 32'h1234_5678);
    applyStimulus(1'b1, MEM_SC, 1'b0, 1'b0, 32'h0000_3000, 32'h0000_0055, 0, 0, 32'h0);
    checkOutput("sc1_req_cycles", obsReqCycles, 32'd1);
    checkOutput("sc1_ctrl", {25'h0, obsCtrl}, {25'h0, 1'b1, 2'd2, 4'b1111});
    checkOutput("sc1_wdata", obsWdata, 32'h0000_0055);
    checkOutput("sc1_result", obsSc, 1'b1);
    checkOutput("sc1_done_cycle", obsDoneCycle, 32'd3);
    applyStimulus(1'b1, MEM_SC, 1'b0, 1'b0, 32'h0000_3000, 32'h0000_0066, 0, 0, 32'h0);
    checkOutput("sc2_req_cycles", obsReqCycles, 32'd0);
    checkOutput("sc2_result", obsSc, 1'b0);
    checkOutput("sc2_done_cycle", obsDoneCycle, 32'd1);

    $display("[TB] ll, llbit_clr, sc");
    applyStimulus(1'b0, MEM_WORD, 1'b0, 1'b1, 32'h0000_3000, 32'h0, 0, 0, 32'h0BAD_F00D);
    @(negedge clk);
    mif.llbit_clr = 1'b1;
    @(negedge clk);
    mif.llbit_clr = 1'b0;
    applyStimulus(1'b1, MEM_SC, 1'b0, 1'b0, 32'h0000_3000, 32'h0000_0077, 0, 0, 32'h0);
    checkOutput("clr_sc_req_cycles", obsReqCycles, 32'd0);
    checkOutput("clr_sc_result", obsSc, 1'b0);

    $display("[TB] misaligned sw to 0x4002");
    applyStimulus(1'b1, MEM_WORD, 1'b0, 1'b0, 32'h0000_4002, 32'h1122_3344, 0, 0, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
    checkOutput("sw_mis_flags", {30'h0, obsAdel, obsAdes}, 32'h1);
    checkOutput("sw_mis_req_cycles", obsReqCycles, 32'd0);
    checkOutput("sw_mis_done_cycle", obsDoneCycle, 32'd1);
`else
    checkOutput("sw_mis_flags", {30'h0, obsAdel, obsAdes}, 32'h0);
    checkOutput("sw_mis_addr", obsAddr, 32'h0000_4000);
    checkOutput("sw_mis_done_cycle", obsDoneCycle, 32'd3);
`endif

    $display("[TB] reset while waiting for data");
    applyStimulus(1'b0, MEM_WORD, 1'b0, 1'b1, 32'h0000_3000, 32'h0, 0, 0, 32'h0000_0001);
    @(negedge clk);
    mif.valid   = 1'b1;
    mif.we      = 1'b0;
    mif.mem_sel = MEM_WORD;
    mif.ll      = 1'b0;
    mif.addr    = 32'h0000_5000;
    @(negedge clk);
    mif.valid        = 1'b0;
    mif.data_addr_ok = 1'b1;
    @(negedge clk);
    mif.data_addr_ok = 1'b0;
    checkOutput("wait_state", {30'h0, mif.data_req, mif.stall}, 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_flags", {27'h0, mif.data_req, mif.stall, mif.done, mif.sc_result, mif.ades}, 32'h0);
    checkOutput("rst_mid_addr", mif.data_addr, 32'h0);
    @(negedge clk);
    rst              = 1'b0;
    mif.data_data_ok = 1'b1;
    mif.data_rdata   = 32'hFFFF_FFFF;
    @(negedge clk);
    mif.data_data_ok = 1'b0;
    checkOutput("late_data_ok", {29'h0, mif.done, mif.stall, mif.data_req}, 32'h0);
    checkOutput("late_rdata", mif.rdata, 32'h0);
    applyStimulus(1'b1, MEM_SC, 1'b0, 1'b0, 32'h0000_3000, 32'h0000_0099, 0, 0, 32'h0);
    checkOutput("rst_sc_req_cycles", obsReqCycles, 32'd0);
    checkOutput("rst_sc_result", obsSc, 1'b0);
    applyStimulus(1'b0, MEM_WORD, 1'b0, 1'b0, 32'h0000_5004, 32'h0, 0, 0, 32'hCAFE_BABE);
    checkOutput("post_rst_done_cycle", obsDoneCycle, 32'd3);
    checkOutput("post_rst_rdata", obsRdata, 32'hCAFE_BABE);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access controller that consumes the access-size code `mem_sel` produced by the EX-stage size decoder and performs the load/store on the SRAM-like data bus. It generates size, byte strobes and lane-replicated write data, runs the `addr_ok`/`data_ok` handshake, and stalls the pipeline until the access completes. It also aligns and extends load data and owns the LL/SC link bit. It sits between the EX/MEM pipeline register and the data-bus bridge.

## Interface
- No parameters (32-bit datapath fixed).
- `clk` in 1: sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `valid` in 1: memory op present in MEM stage.
- `we` in 1: 1 = store/sc, 0 = load.
- `mem_sel` in 2: 0 sc, 1 byte, 2 half, 3 word.
- `sign_ext` in 1: sign-extend byte/half loads (lb/lh).
- `ll` in 1: load is load-linked (word).
- `llbit_clr` in 1: eret/exception clears link bit.
- `addr` in 32: effective address.
- `wdata` in 32: store data (low-aligned).
- `rdata` out 32: aligned/extended load result.
- `done` out 1: one-cycle completion pulse.
- `stall` out 1: hold pipeline.
- `sc_result` out 1: sc success (1) / fail (0).
- `adel`, `ades` out 1 each: misaligned load/store, valid with `done`.
- `data_req` out 1, `data_wr` out 1, `data_size` out 2, `data_wstrb` out 4, `data_addr` out 32, `data_wdata` out 32.
- `data_addr_ok` in 1, `data_data_ok` in 1, `data_rdata` in 32.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: on `valid`, latch all request inputs; misaligned → DONE with flag set, no bus op. sc with link bit 0 → DONE, `sc_result`=0, no bus op. Otherwise → REQ.
- REQ: `data_req`=1 with stable address/controls; `data_addr_ok`=1 → WAIT.
- WAIT: `data_data_ok`=1 → DONE; latch `data_rdata`.
- DONE: `done`=1 for one cycle → IDLE.
- Size: byte `data_size`=0, half 1, word/sc 2. `data_addr` = latched addr, full 32 bits.
- Strobe (little-endian): byte `1<<a[1:0]`, half `3<<a[1:0]`, word/sc `4'hF`; `data_wstrb`=0 for loads.
- Write data: byte `{4{wdata[7:0]}}`, half `{2{wdata[15:0]}}`, word unchanged.
- Load: shift `data_rdata` right by `8*a[1:0]`, take 8/16/32 bits, sign- or zero-extend per `sign_ext`.
- Link bit: set when ll load's `data_data_ok` arrives; cleared on sc completion (success or fail) and on `llbit_clr`; `llbit_clr` wins over simultaneous set.
- `sc_result`=1 only when sc store completed on bus.
- `data_data_ok` in IDLE/REQ/DONE ignored.

## Timing
- Reset values: state IDLE; all outputs 0 (`rdata`, `done`, `stall`, `sc_result`, `adel`, `ades`, all bus outputs); link bit 0.
- `stall` combinational = (IDLE & `valid`) | REQ | WAIT; 0 in DONE.
- `rdata`, `sc_result`, `adel`, `ades` registered; valid in DONE and held until next request latch.
- Minimum bus-access latency: `valid` cycle 0, `data_req` cycle 1, `addr_ok` cycle 1, `data_ok` cycle 2, `done` cycle 3.
- Short-circuit (fail sc, misaligned): `done` cycle 1.
- Back-to-back: new `valid` in the cycle after DONE is accepted.
- Reset mid-operation: immediate return to IDLE, `data_req` drops, link bit cleared; late `data_ok` ignored.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined: half with `a[0]`=1 or word/sc with `a[1:0]`≠0 raises `adel`/`ades` and skips the bus.
- Undefined: no check, `adel`/`ades` tied 0; low address bits forced to 0 for half (bit 0) and word (bits 1:0) on `data_addr` and in alignment.

## Structure
- Package `mem_pkg`: `mem_sel` encodings (MEM_SC, MEM_BYTE, MEM_HALF, MEM_WORD), `data_size` encodings, FSM state enum.
- Sub-module `llbit_reg`: link-bit flop with set/clear/priority and async reset.

## Test plan
- sb, addr 0x1003, wdata 0xAB, addr_ok/data_ok immediate → wstrb 4'b1000, wdata 0xABABABAB, size 0, done at cycle 3.
- lh, addr 0x2002, rdata 0x8001_1234, sign_ext=1 → rdata 0xFFFF8001; sign_ext=0 → 0x00008001.
- lw with addr_ok delayed 4 cycles, data_ok 3 later → data_req held stable, stall high throughout, single done pulse.
- ll 0x3000 then sc 0x3000 → sc bus store, sc_result 1; second sc → no data_req, sc_result 0, done at cycle 1.
- ll, then llbit_clr, then sc → sc_result 0, no bus op.
- With `MEM_ALIGN_CHECK_EN`: sw addr 0x4002 → ades 1, no data_req; rst asserted in WAIT → all outputs 0, next request normal.
